// File: rtl/digitron_scan_sched_if.sv
// rtl/digitron_scan_sched_if.sv - display scan bus between the scheduler and its driver/observer
interface digitron_scan_sched_if;
    logic [7:0] smg_1_i;
    logic [7:0] smg_2_i;
    logic [7:0] smg_3_i;
    logic [7:0] smg_4_i;
    logic [7:0] smg_5_i;
    logic [7:0] smg_6_i;
    logic [5:0] en_i;
    logic [3:0] bright_i;
    logic [7:0] row_o;
    logic [5:0] column_o;
    logic [2:0] digit_idx_o;
    logic       frame_o;
    logic       idle_o;

    modport slave (
        input  smg_1_i, smg_2_i, smg_3_i, smg_4_i, smg_5_i, smg_6_i,
        input  en_i, bright_i,
        output row_o, column_o, digit_idx_o, frame_o, idle_o
    );

    modport master (
        output smg_1_i, smg_2_i, smg_3_i, smg_4_i, smg_5_i, smg_6_i,
        output en_i, bright_i,
        input  row_o, column_o, digit_idx_o, frame_o, idle_o
    );
endinterface

// File: rtl/digitron_scan_sched.sv
// rtl/digitron_scan_sched.sv - six-digit seven-segment scan scheduler
// Slot = BLANK, ON for (b+1) steps, OFF; codes are frozen per frame to avoid tearing.
module digitron_scan_sched #(
    parameter int TICK_DIV  = 40000,
    parameter int BLANK_CYC = 200,
    parameter int STEP_CYC  = 2000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    digitron_scan_sched_if.slave  bus
);
    if (TICK_DIV < 1 || BLANK_CYC < 1 || STEP_CYC < 1 ||
        BLANK_CYC + 16 * STEP_CYC > TICK_DIV) begin : g_param_check
        $error("digitron_scan_sched: invalid slot timing parameters");
    end

    localparam int            CW   = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON, S_OFF} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    bright_q, bright_d;
    logic [7:0]    snap_q [6];
    logic [7:0]    snap_d [6];
    logic [7:0]    live [6];
    logic [7:0]    row_q, row_d;
    logic [5:0]    col_q, col_d;
    logic          frame_q, frame_d;
    logic          idle_q, idle_d;
    logic [2:0]    next_idx, low_idx, cand;
    logic [31:0]   cnt_ext, on_end;

    function automatic logic [2:0] wrap_add(input logic [2:0] a, input logic [2:0] k);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, k};
        return (s >= 4'd6) ? 3'(s - 4'd6) : s[2:0];
    endfunction

    always_comb begin
        live[0] = bus.smg_1_i;
        live[1] = bus.smg_2_i;
        live[2] = bus.smg_3_i;
        live[3] = bus.smg_4_i;
        live[4] = bus.smg_5_i;
        live[5] = bus.smg_6_i;
    end

    // Later assignments win, so the nearest enabled digit after idx_q is chosen.
    always_comb begin
        next_idx = idx_q;
        cand     = idx_q;
        for (int k = 5; k >= 1; k--) begin
            cand = wrap_add(idx_q, 3'(k));
            if (bus.en_i[cand]) next_idx = cand;
        end
        low_idx = 3'd0;
        for (int k = 5; k >= 0; k--) begin
            if (bus.en_i[k]) low_idx = 3'(k);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        bright_d = bright_q;
        snap_d   = snap_q;
        frame_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.en_i != 6'd0) begin
                    state_d  = S_BLANK;
                    idx_d    = low_idx;
                    bright_d = bus.bright_i;
                    snap_d   = live;
                    frame_d  = 1'b1;
                end
            end
            default: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (bus.en_i == 6'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_BLANK;
                        idx_d    = next_idx;
                        bright_d = bus.bright_i;
                        frame_d  = (next_idx <= idx_q);
                        if (next_idx <= idx_q) snap_d = live;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        cnt_ext = 32'(cnt_d);
        on_end  = 32'(BLANK_CYC) + (32'(bright_d) + 32'd1) * 32'(STEP_CYC);
        if (state_d != S_IDLE) begin
            if (cnt_ext < 32'(BLANK_CYC))  state_d = S_BLANK;
            else if (cnt_ext < on_end)     state_d = S_ON;
            else                           state_d = S_OFF;
        end

        // Outputs follow the next state so segments and column switch together.
        idle_d = (state_d == S_IDLE);
        col_d  = (state_d == S_ON) ? ~(6'b000001 << idx_d) : 6'h3F;
        row_d  = (state_d == S_ON) ? snap_d[idx_d] : 8'hFF;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            bright_q <= 4'd0;
            for (int k = 0; k < 6; k++) snap_q[k] <= 8'hFF;
            row_q    <= 8'hFF;
            col_q    <= 6'h3F;
            frame_q  <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            bright_q <= bright_d;
            for (int k = 0; k < 6; k++) snap_q[k] <= snap_d[k];
            row_q    <= row_d;
            col_q    <= col_d;
            frame_q  <= frame_d;
            idle_q   <= idle_d;
        end
    end

    assign bus.row_o       = row_q;
    assign bus.column_o    = col_q;
    assign bus.digit_idx_o = idx_q;
    assign bus.frame_o     = frame_q;
    assign bus.idle_o      = idle_q;
endmodule

// File: tb/tb_digitron_scan_sched.sv
// tb/tb_digitron_scan_sched.sv - directed bench for the scan scheduler (TICK_DIV=64, BLANK_CYC=4, STEP_CYC=3)
module tb_digitron_scan_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    digitron_scan_sched_if dif ();

    digitron_scan_sched #(.TICK_DIV(64), .BLANK_CYC(4), .STEP_CYC(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge where slot cycle 0 is visible; leaves at the next slot's cycle 0.
    task automatic run_slot(input int idx, input int b, input bit fr, input logic [7:0] code);
        logic [5:0] exp_col;
        logic [7:0] exp_row;
        bit         on;
        for (int s = 0; s < 64; s++) begin
            on      = (s >= 4) && (s < 4 + (b + 1) * 3);
            exp_col = on ? ~(6'b000001 << idx) : 6'h3F;
            exp_row = on ? code : 8'hFF;
            chk("digit_idx", 32'(dif.digit_idx_o), 32'(idx));
            chk("column", 32'(dif.column_o), 32'(exp_col));
            chk("row", 32'(dif.row_o), 32'(exp_row));
            chk("frame", 32'(dif.frame_o), 32'((s == 0) && fr));
            chk("idle", 32'(dif.idle_o), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_idle"}, 32'(dif.idle_o), 32'd1);
        chk({tag, "_column"}, 32'(dif.column_o), 32'h3F);
        chk({tag, "_row"}, 32'(dif.row_o), 32'hFF);
        chk({tag, "_frame"}, 32'(dif.frame_o), 32'd0);
    endtask

    initial begin
        dif.smg_1_i  = 8'h01;
        dif.smg_2_i  = 8'h02;
        dif.smg_3_i  = 8'h03;
        dif.smg_4_i  = 8'h04;
        dif.smg_5_i  = 8'h05;
        dif.smg_6_i  = 8'h06;
        dif.en_i     = 6'h3F;
        dif.bright_i = 4'd15;
        repeat (3) @(negedge clk);
        chk_off("reset");
        chk("reset_idx", 32'(dif.digit_idx_o), 32'd0);

        // Full scan at maximum brightness: one frame of six slots.
        rst = 1'b0;
        @(negedge clk);
        run_slot(0, 15, 1, 8'h01);
        run_slot(1, 15, 0, 8'h02);
        run_slot(2, 15, 0, 8'h03);
        run_slot(3, 15, 0, 8'h04);
        run_slot(4, 15, 0, 8'h05);
        run_slot(5, 15, 0, 8'h06);

        // Single digit at minimum brightness; current slot keeps old settings.
        dif.bright_i = 4'd0;
        dif.en_i     = 6'h01;
        run_slot(0, 15, 1, 8'h01);
        run_slot(0, 0, 1, 8'h01);
        run_slot(0, 0, 1, 8'h01);

        // Digits 3 and 6 alternate; frame only on digit 3.
        dif.en_i = 6'b100100;
        run_slot(0, 0, 1, 8'h01);
        run_slot(2, 0, 0, 8'h03);
        run_slot(5, 0, 0, 8'h06);

        // Back to all digits; then change digit 2 code mid-frame.
        dif.en_i     = 6'h3F;
        dif.bright_i = 4'd15;
        run_slot(2, 0, 1, 8'h03);
        run_slot(3, 15, 0, 8'h04);
        run_slot(4, 15, 0, 8'h05);
        run_slot(5, 15, 0, 8'h06);
        dif.smg_2_i = 8'hA5;
        run_slot(0, 15, 1, 8'h01);
        run_slot(1, 15, 0, 8'h02);
        run_slot(2, 15, 0, 8'h03);
        run_slot(3, 15, 0, 8'h04);
        run_slot(4, 15, 0, 8'h05);
        run_slot(5, 15, 0, 8'h06);
        run_slot(0, 15, 1, 8'h01);
        run_slot(1, 15, 0, 8'hA5);

        // Disable everything mid-slot: slot completes, then idle.
        dif.en_i = 6'h00;
        run_slot(2, 15, 0, 8'h03);
        for (int i = 0; i < 4; i++) begin
            chk_off("idle");
            @(negedge clk);
        end
        dif.en_i = 6'h10;
        @(negedge clk);
        run_slot(4, 15, 1, 8'h05);

        // Reset during ON phase of the reselected digit 5.
        repeat (10) @(negedge clk);
        chk("on_column", 32'(dif.column_o), 32'h2F);
        chk("on_row", 32'(dif.row_o), 32'h05);
        rst = 1'b1;
        @(negedge clk);
        chk_off("midreset");
        chk("midreset_idx", 32'(dif.digit_idx_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
